// File: rtl/fixed_point_alu_seq.sv
// ============================================================================
//  Module   : fixed_point_alu_seq
//  Purpose  : Handshaked sequential fixed-point ALU for signed QI.F operands.
//             ADD/SUB/NEG/ABS/MIN/MAX take one cycle. MUL takes two.
//             DIV is an iterative restoring divider that produces one
//             quotient bit per cycle. Overflow and divide-by-zero are flagged.
//  Option   : FP_ALU_SATURATE_EN - when defined, an overflowing result is
//             clamped. Otherwise it wraps in two's complement.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_point_alu_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 20
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] d0_in,
  input  logic [WIDTH-1:0] d1_in,
  input  logic [2:0]       sel_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] res_out,
  output logic             gt_out,
  output logic             eq_out,
  output logic             ovf_out,
  output logic             dz_out
);

  // Dividend width: |a| shifted left by FRAC.
  localparam int DW = WIDTH + FRAC;
  localparam int CW = $clog2(DW + 1);

  localparam logic [WIDTH-1:0]   MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MAX_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DW-1:0]      LIM_POS  = {{FRAC{1'b0}}, MAX_POS};
  localparam logic [DW-1:0]      LIM_NEG  = {{FRAC{1'b0}}, MAX_NEG};
  localparam logic [2*WIDTH-1:0] TOP_ONES = {{(WIDTH+FRAC-1){1'b0}}, {(WIDTH-FRAC+1){1'b1}}};
  localparam logic [CW-1:0]      CNT_LAST = CW'(DW - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_ABS = 3'b101;
  localparam logic [2:0] OP_MIN = 3'b110;
  localparam logic [2:0] OP_MAX = 3'b111;

  // Saturation only changes the value driven on overflow; flags are identical.
`ifdef FP_ALU_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL2    = 3'd1,
    DIV_RUN = 3'd2,
    DIV_FIX = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, state_n, launch_state;

  logic             accept;
  logic [WIDTH-1:0] a_q, b_q;
  logic             neg_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem_q;
  logic [DW-1:0]    dq_q;
  logic [CW-1:0]    cnt_q;

  // Single-cycle path, evaluated straight from the request inputs
  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] neg_a, abs_a, abs_b;
  logic             a_is_min, a_gt_b, a_eq_b, b_zero;
  logic [WIDTH-1:0] q_wrap, q_sat, q_res;
  logic             q_ovf, q_neg, q_dz;

  // Multiplier path
  logic [2*WIDTH-1:0] prod, top_bits;
  logic [WIDTH-1:0]   mul_wrap, mul_res;
  logic               mul_ovf;

  // Divider iteration and sign fix-up
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] q_low, div_wrap, div_res;
  logic             div_ovf;

  // Ready is withheld during reset so no request is accepted and then dropped.
  always_comb begin
    ready_out = 1'b0;
    valid_out = 1'b0;
    if (!rst_in) begin
      ready_out = (state == IDLE) || ((state == DONE) && ready_in);
    end
    valid_out = (state == DONE);
    accept    = valid_in && ready_out;
  end

  // Pick the state a freshly accepted request starts in.
  always_comb begin
    launch_state = DONE;
    if (sel_in == OP_MUL) begin
      launch_state = MUL2;
    end else if ((sel_in == OP_DIV) && !b_zero) begin
      launch_state = DIV_RUN;
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = launch_state;
      MUL2:    state_n = DONE;
      DIV_RUN: if (cnt_q == CNT_LAST) state_n = DIV_FIX;
      DIV_FIX: state_n = DONE;
      DONE:    if (ready_in) state_n = accept ? launch_state : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Compare, add/sub, neg/abs and the divide-by-zero clamp for the new request.
  always_comb begin
    sum_add  = {d0_in[WIDTH-1], d0_in} + {d1_in[WIDTH-1], d1_in};
    sum_sub  = {d0_in[WIDTH-1], d0_in} - {d1_in[WIDTH-1], d1_in};
    neg_a    = -d0_in;
    abs_a    = d0_in[WIDTH-1] ? neg_a : d0_in;
    abs_b    = d1_in[WIDTH-1] ? -d1_in : d1_in;
    a_is_min = (d0_in == MAX_NEG);
    a_gt_b   = $signed(d0_in) > $signed(d1_in);
    a_eq_b   = (d0_in == d1_in);
    b_zero   = (d1_in == '0);
    q_wrap   = '0;
    q_ovf    = 1'b0;
    q_neg    = 1'b0;
    q_dz     = 1'b0;
    case (sel_in)
      OP_ADD: begin
        q_wrap = sum_add[WIDTH-1:0];
        q_ovf  = sum_add[WIDTH] ^ sum_add[WIDTH-1];
        q_neg  = sum_add[WIDTH];
      end
      OP_SUB: begin
        q_wrap = sum_sub[WIDTH-1:0];
        q_ovf  = sum_sub[WIDTH] ^ sum_sub[WIDTH-1];
        q_neg  = sum_sub[WIDTH];
      end
      OP_DIV: begin
        // Only reaches the output when b == 0; otherwise the divider runs.
        q_dz   = b_zero;
        q_ovf  = b_zero;
        q_neg  = d0_in[WIDTH-1];
      end
      OP_NEG: begin
        q_wrap = neg_a;
        q_ovf  = a_is_min;
      end
      OP_ABS: begin
        q_wrap = abs_a;
        q_ovf  = a_is_min;
      end
      OP_MIN:  q_wrap = a_gt_b ? d1_in : d0_in;
      OP_MAX:  q_wrap = a_gt_b ? d0_in : d1_in;
      default: q_wrap = '0;
    endcase
    q_sat = q_neg ? MAX_NEG : MAX_POS;
    // Divide-by-zero always clamps; other overflows clamp only when saturating.
    q_res = (q_dz || (SAT_EN && q_ovf)) ? q_sat : q_wrap;
  end

  // Full-width product of the registered operands and its range check.
  always_comb begin
    prod     = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    top_bits = prod >> (WIDTH + FRAC - 1);
    mul_ovf  = (top_bits != '0) && (top_bits != TOP_ONES);
    mul_wrap = WIDTH'(prod >> FRAC);
    mul_res  = (SAT_EN && mul_ovf) ? (prod[2*WIDTH-1] ? MAX_NEG : MAX_POS) : mul_wrap;
  end

  // One restoring-division step, plus sign application for the final quotient.
  always_comb begin
    trial    = {rem_q, dq_q[DW-1]};
    ge       = (trial >= {1'b0, div_q});
    rem_n    = ge ? WIDTH'(trial - {1'b0, div_q}) : WIDTH'(trial);
    q_low    = dq_q[WIDTH-1:0];
    div_wrap = neg_q ? -q_low : q_low;
    div_ovf  = neg_q ? (dq_q > LIM_NEG) : (dq_q > LIM_POS);
    div_res  = (SAT_EN && div_ovf) ? (neg_q ? MAX_NEG : MAX_POS) : div_wrap;
  end

  // Operand capture, divider iteration and result/flag registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      div_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      cnt_q   <= '0;
      res_out <= '0;
      gt_out  <= 1'b0;
      eq_out  <= 1'b0;
      ovf_out <= 1'b0;
      dz_out  <= 1'b0;
    end else if (accept) begin
      a_q     <= d0_in;
      b_q     <= d1_in;
      neg_q   <= d0_in[WIDTH-1] ^ d1_in[WIDTH-1];
      div_q   <= abs_b;
      rem_q   <= '0;
      dq_q    <= {abs_a, {FRAC{1'b0}}};
      cnt_q   <= '0;
      gt_out  <= a_gt_b;
      eq_out  <= a_eq_b;
      res_out <= q_res;
      ovf_out <= q_ovf;
      dz_out  <= q_dz;
    end else begin
      case (state)
        MUL2: begin
          res_out <= mul_res;
          ovf_out <= mul_ovf;
        end
        DIV_RUN: begin
          rem_q <= rem_n;
          dq_q  <= {dq_q[DW-2:0], ge};
          cnt_q <= cnt_q + 1'b1;
        end
        DIV_FIX: begin
          res_out <= div_res;
          ovf_out <= div_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none

module tb_fixed_point_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] d0;
  logic [31:0] d1;
  logic [2:0]  sel;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] res;
  logic        gt, eq, ovf, dz;

  int n_assert = 0;
  int n_fail   = 0;

  fixed_point_alu_seq #(.WIDTH(32), .FRAC(20)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .d0_in    (d0),
    .d1_in    (d1),
    .sel_in   (sel),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .res_out  (res),
    .gt_out   (gt),
    .eq_out   (eq),
    .ovf_out  (ovf),
    .dz_out   (dz)
  );

  always #5 clk = ~clk;

`ifdef FP_ALU_SATURATE_EN
  localparam logic [31:0] ADD_OVF_RES = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OVF_RES = 32'h7FFF_FFFF;
  localparam logic [31:0] MUL_OVF_RES = 32'h7FFF_FFFF;
  localparam logic [31:0] DIV_OVF_RES = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] ADD_OVF_RES = 32'h8000_0000;
  localparam logic [31:0] NEG_OVF_RES = 32'h8000_0000;
  localparam logic [31:0] MUL_OVF_RES = 32'hFFE0_0000;
  localparam logic [31:0] DIV_OVF_RES = 32'h8000_0000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge, then scramble the operand pins.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    valid_in = 1'b1;
    d0 = a;
    d1 = b;
    sel = op;
    tick();
    valid_in = 1'b0;
    d0 = $urandom;
    d1 = $urandom;
    sel = 3'($urandom_range(0, 7));
  endtask

  // Count cycles after the accept edge until valid_out, noting any ready_out.
  task automatic wait_valid(output int lat, output logic rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (!valid_out && lat < 200) begin
      rdy_seen = rdy_seen | ready_out;
      tick();
      lat++;
    end
  endtask

  int   lat;
  logic rdy_seen;
  logic held_ok;
  logic ghost;

  initial begin
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    d0 = '0; d1 = '0; sel = '0;
    tick(); tick();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_res", res, 32'h0);
    check("rst_flags", {28'd0, gt, eq, ovf, dz}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(ready_out), 32'd1);

    // ADD 3.0 + 2.5
    issue(32'h0030_0000, 32'h0028_0000, 3'b000);
    check("add_valid", 32'(valid_out), 32'd1);
    check("add_res", res, 32'h0058_0000);
    check("add_flags", {28'd0, gt, eq, ovf, dz}, 32'b1000);
    tick();
    check("add_consumed", 32'(valid_out), 32'd0);

    // SUB of equal operands sets eq
    issue(32'h0010_0000, 32'h0010_0000, 3'b001);
    check("sub_eq_res", res, 32'h0);
    check("sub_eq_flags", {28'd0, gt, eq, ovf, dz}, 32'b0100);
    tick();

    // SUB 2.5 - 3.0
    issue(32'h0028_0000, 32'h0030_0000, 3'b001);
    check("sub_res", res, 32'hFFF8_0000);
    tick();

    // MUL 1.5 * -2.0, two-cycle latency
    issue(32'h0018_0000, 32'hFFE0_0000, 3'b010);
    check("mul_not_yet", 32'(valid_out), 32'd0);
    tick();
    check("mul_valid", 32'(valid_out), 32'd1);
    check("mul_res", res, 32'hFFD0_0000);
    check("mul_flags", {28'd0, gt, eq, ovf, dz}, 32'b1000);
    tick();

    // MUL 2047.0 * 2.0 overflows
    issue(32'h7FF0_0000, 32'h0020_0000, 3'b010);
    tick();
    check("mul_ovf_res", res, MUL_OVF_RES);
    check("mul_ovf", 32'(ovf), 32'd1);
    tick();

    // DIV 7.0 / 2.0
    issue(32'h0070_0000, 32'h0020_0000, 3'b011);
    wait_valid(lat, rdy_seen);
    check("div_latency", 32'(lat), 32'd54);
    check("div_ready_low", 32'(rdy_seen), 32'd0);
    check("div_res", res, 32'h0038_0000);
    check("div_flags", {28'd0, gt, eq, ovf, dz}, 32'b1000);
    tick();

    // DIV -1.0 / 0.5 exercises sign fix-up
    issue(32'hFFF0_0000, 32'h0008_0000, 3'b011);
    wait_valid(lat, rdy_seen);
    check("div_neg_res", res, 32'hFFE0_0000);
    tick();

    // DIV 1024.0 / 0.5 overflows
    issue(32'h4000_0000, 32'h0008_0000, 3'b011);
    wait_valid(lat, rdy_seen);
    check("div_ovf_res", res, DIV_OVF_RES);
    check("div_ovf", 32'(ovf), 32'd1);
    tick();

    // DIV by zero, negative dividend, single-cycle latency
    issue(32'hFFF0_0000, 32'h0000_0000, 3'b011);
    check("dz_valid", 32'(valid_out), 32'd1);
    check("dz_res", res, 32'h8000_0000);
    check("dz_flags", {28'd0, gt, eq, ovf, dz}, 32'b0011);
    tick();

    // ADD overflow
    issue(32'h7FF0_0000, 32'h0010_0000, 3'b000);
    check("add_ovf_res", res, ADD_OVF_RES);
    check("add_ovf", 32'(ovf), 32'd1);
    tick();

    // NEG of most-negative
    issue(32'h8000_0000, 32'h0, 3'b100);
    check("neg_min_res", res, NEG_OVF_RES);
    check("neg_min_ovf", 32'(ovf), 32'd1);
    tick();

    // ABS -2.0, MIN(3.0, -2.0)
    issue(32'hFFE0_0000, 32'h0, 3'b101);
    check("abs_res", res, 32'h0020_0000);
    check("abs_ovf", 32'(ovf), 32'd0);
    tick();
    issue(32'h0030_0000, 32'hFFE0_0000, 3'b110);
    check("min_res", res, 32'hFFE0_0000);
    tick();

    // MAX held for 5 cycles with ready_in low
    ready_in = 1'b0;
    issue(32'h0008_0000, 32'hFFF0_0000, 3'b111);
    held_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(valid_out === 1'b1 && res === 32'h0008_0000 && gt === 1'b1 &&
            eq === 1'b0 && ovf === 1'b0 && dz === 1'b0 && ready_out === 1'b0))
        held_ok = 1'b0;
      tick();
    end
    check("max_hold", 32'(held_ok), 32'd1);
    check("max_res", res, 32'h0008_0000);
    // Consume and issue on the same edge
    ready_in = 1'b1;
    valid_in = 1'b1;
    d0 = 32'h0010_0000; d1 = 32'h0010_0000; sel = 3'b000;
    #1;
    check("b2b_ready", 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0;
    check("b2b_valid", 32'(valid_out), 32'd1);
    check("b2b_res", res, 32'h0020_0000);
    check("b2b_eq", 32'(eq), 32'd1);
    tick();

    // Reset in the middle of a DIV
    issue(32'h0070_0000, 32'h0020_0000, 3'b011);
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_valid", 32'(valid_out), 32'd0);
    check("abort_ready", 32'(ready_out), 32'd1);
    ghost = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ghost = ghost | valid_out;
      tick();
    end
    check("abort_no_result", 32'(ghost), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fixed_point_alu_seq.md
Name: fixed_point_alu_seq

Overview:
- Parametrised, handshaked, sequential successor to the combinational fixed-point ALU. It operates on signed two's-complement QI.F operands, with WIDTH total bits and FRAC fraction bits (default Q12.20).
- Adds three things: an iterative divider, a pipelined multiplier, and overflow and divide-by-zero reporting.
- Sits between the ray-marcher datapath control and any consumer that needs one fixed-point result per request, using valid/ready on both sides.

Parameters:
- WIDTH, 32: total operand/result bits; legal range 8..48.
- FRAC, 20: fraction bits; must satisfy 0 < FRAC < WIDTH.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- valid_in  input  1  request valid
- ready_out  output  1  block can accept a request this cycle
- d0_in  input  WIDTH  operand a, signed QI.F
- d1_in  input  WIDTH  operand b, signed QI.F
- sel_in  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 NEG(a), 101 ABS(a), 110 MIN, 111 MAX
- valid_out  output  1  result valid
- ready_in  input  1  consumer accepts result
- res_out  output  WIDTH  result
- gt_out  output  1  a > b (signed), captured with the request
- eq_out  output  1  a == b, captured with the request
- ovf_out  output  1  result out of representable range
- dz_out  output  1  DIV with b == 0

Behaviour:
- Reset: any cycle with rst_in=1 forces state IDLE and, on the next edge, sets valid_out=0, res_out=0, gt_out=0, eq_out=0, ovf_out=0, dz_out=0. Any in-flight operation is discarded and no result is emitted. ready_out=1 from the first cycle after reset deasserts.
- Accept:
  - A request is taken on an edge where valid_in && ready_out. This edge is cycle N.
  - Operands and opcode are registered at that edge; later changes on d0_in, d1_in and sel_in are ignored.
- ready_out:
  - 1 in IDLE.
  - 1 in DONE when ready_in=1.
  - 0 otherwise.
  - Consequence: back-to-back issue is allowed on the same edge the previous result is consumed.
- FSM states:
  - IDLE: on accept, ADD/SUB/NEG/ABS/MIN/MAX go to DONE; MUL goes to MUL2; DIV goes to DIV_RUN.
  - MUL2: registers the full 2*WIDTH signed product, then goes to DONE.
  - DIV_RUN: unsigned restoring division of (|a| << FRAC) by |b|. One quotient bit per cycle, WIDTH+FRAC iterations, counter-driven, then goes to DIV_FIX.
  - DIV_FIX: applies sign (a XOR b), checks range, goes to DONE.
  - DONE: valid_out=1. Outputs are held stable while ready_in=0. On ready_in=1, goes to IDLE, or loads the new request if valid_in=1.
- Latency (valid_out first high at cycle N+L):
  - L=1 for ADD, SUB, NEG, ABS, MIN, MAX.
  - L=2 for MUL.
  - L=WIDTH+FRAC+2 for DIV (54 at defaults).
  - A DIV with b=0 skips iteration and has L=1.
- Arithmetic:
  - ADD/SUB: WIDTH+1-bit internally; overflow when the two top bits differ.
  - MUL: result = product[WIDTH+FRAC-1 : FRAC], truncated toward -inf. Overflow if product bits above WIDTH+FRAC-1 are not all sign extension.
  - DIV: quotient truncated toward zero; overflow if the magnitude exceeds the range of the result sign.
  - NEG/ABS: the most-negative input overflows.
  - MIN/MAX: select by signed compare; they never overflow.
- gt_out/eq_out: valid for every opcode, presented with the result.
- Divide by zero: dz_out=1, ovf_out=1. res_out = most-positive if a >= 0, else most-negative. This holds regardless of the macro.
- ovf_out is reported identically with and without the optional feature. Only res_out differs.
- valid_in while not ready is ignored; the request is not queued.

Optional Feature:
- Macro: FP_ALU_SATURATE_EN.
- Defined: on overflow, res_out is clamped to most-positive (0x7FFF_FFFF at defaults) or most-negative (0x8000_0000) according to the true sign. NEG and ABS of the most-negative value give most-positive.
- Undefined: on overflow, res_out is the low WIDTH bits of the wrapped result (two's-complement wrap).

Test Plan:
- ADD a=0x0030_0000 (3.0), b=0x0028_0000 (2.5) -> cycle N+1: res=0x0058_0000, gt=1, eq=0, ovf=0.
- MUL a=0x0018_0000 (1.5), b=0xFFE0_0000 (-2.0) -> cycle N+2: res=0xFFD0_0000 (-3.0), gt=1.
- DIV a=0x0070_0000, b=0x0020_0000 -> ready_out=0 for cycles N+1..N+53, then cycle N+54: res=0x0038_0000. Separately, DIV a=0xFFF0_0000, b=0 -> N+1: res=0x8000_0000, dz=1, ovf=1.
- ADD a=0x7FF0_0000, b=0x0010_0000 -> ovf=1, res=0x8000_0000 without macro; res=0x7FFF_FFFF with FP_ALU_SATURATE_EN.
- MAX result held with ready_in=0 for 5 cycles -> res/flags/valid_out stable and ready_out=0. Then ready_in=1 with a new valid ADD on the same edge -> new request accepted and its result is valid on the next cycle.
- Reset mid-DIV at N+10 -> valid_out=0 and ready_out=1 from the next cycle; no result for the aborted DIV ever appears.
